// File: rtl/alu_pkg.sv
// Shared ALU opcode and sequencer state definitions.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NOT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_LOAD = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    localparam logic [3:0] OP_LOAD = 4'd9;

endpackage

// File: rtl/alu.sv
// Combinational ALU; opcodes without a defined function (LOAD, 10-15) return zero.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_MUL: result = a * b;
            // Division by zero saturates to all ones rather than trapping.
            ALU_DIV: result = (b == '0) ? '1 : a / b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOT: result = ~a;
            ALU_SLL: result = a << b;
            ALU_SRL: result = a >> b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: accepts commands, drives an external ALU for LAT cycles,
// writes the result back into the accumulator and returns it as a response.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         busy
);

    localparam int unsigned CW = $clog2(LAT + 1);

    seq_state_t     state, state_nxt;
    logic [N-1:0]   acc, acc_nxt;
    logic [N-1:0]   data_q, data_nxt;
    logic [3:0]     op_q, op_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            data_q <= '0;
            op_q   <= 4'd0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            data_q <= data_nxt;
            op_q   <= op_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        data_nxt  = data_q;
        op_nxt    = op_q;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nxt   = cmd_op;
                    data_nxt = cmd_data;
                    if (cmd_op == OP_LOAD) begin
                        acc_nxt   = cmd_data;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                // Sample the ALU only after its operands have been held LAT cycles.
                if (cnt == CW'(LAT - 1)) begin
                    acc_nxt   = alu_result;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs decode registered state; rst only masks cmd_ready.
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = acc;
    assign rsp_zero  = (acc == '0);
    assign alu_a     = acc;
    assign alu_b     = data_q;
    assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (LAT=1 and LAT=3) each wired to an alu,
// directed scenarios plus random command streams against an arithmetic model.
module tb_alu_sequencer;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst        [NI];
    logic       cmd_valid  [NI];
    logic       cmd_ready  [NI];
    logic [3:0] cmd_op     [NI];
    logic [7:0] cmd_data   [NI];
    logic [7:0] alu_a      [NI];
    logic [7:0] alu_b      [NI];
    logic [3:0] alu_op     [NI];
    logic [7:0] alu_result [NI];
    logic       rsp_valid  [NI];
    logic       rsp_ready  [NI];
    logic [7:0] rsp_data   [NI];
    logic       rsp_zero   [NI];
    logic       busy       [NI];

    int total = 0;
    int bad   = 0;
    int acc_m [NI];

    alu_sequencer #(.N(8), .LAT(1)) u_seq1 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_op(alu_op[0]), .alu_result(alu_result[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_zero(rsp_zero[0]),
        .busy(busy[0])
    );
    alu #(.N(8)) u_alu1 (.a(alu_a[0]), .b(alu_b[0]), .op(alu_op[0]), .result(alu_result[0]));

    alu_sequencer #(.N(8), .LAT(3)) u_seq3 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_op(alu_op[1]), .alu_result(alu_result[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_zero(rsp_zero[1]),
        .busy(busy[1])
    );
    alu #(.N(8)) u_alu3 (.a(alu_a[1]), .b(alu_b[1]), .op(alu_op[1]), .result(alu_result[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Expected accumulator after applying op with operand b to accumulator a.
    function automatic int ref_op(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * b) % 256;
            3: return (b == 0) ? 255 : a / b;
            4: return a & b;
            5: return a | b;
            6: return 255 - a;
            7: return (b >= 8) ? 0 : (a * (1 << b)) % 256;
            8: return (b >= 8) ? 0 : a / (1 << b);
            9: return b;
            default: return 0;
        endcase
    endfunction

    // Issue one command from IDLE, check EXEC-phase behaviour and response timing,
    // hold the response for 'hold' cycles; optionally present a LOAD of 'pend' meanwhile.
    task automatic do_cmd(input int k, input int op, input int d, input int hold, input int pend);
        int exp;
        int rc;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready[k]), 32'd1);
        cmd_valid[k] = 1'b1;
        cmd_op[k]    = 4'(op);
        cmd_data[k]  = 8'(d);
        @(posedge clk);
        exp = ref_op(op, acc_m[k], d);
        rc  = (op == 9) ? 1 : lat_of(k) + 1;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        for (int c = 1; c < rc; c++) begin
            check("exec_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("exec_cmd_ready", 32'(cmd_ready[k]), 32'd0);
            check("exec_busy", 32'(busy[k]), 32'd1);
            check("exec_alu_a", 32'(alu_a[k]), 32'(acc_m[k]));
            check("exec_alu_b", 32'(alu_b[k]), 32'(d));
            check("exec_alu_op", 32'(alu_op[k]), 32'(op));
            @(negedge clk);
        end
        acc_m[k] = exp;
        check("rsp_valid", 32'(rsp_valid[k]), 32'd1);
        check("rsp_data", 32'(rsp_data[k]), 32'(exp));
        check("rsp_zero", 32'(rsp_zero[k]), 32'(exp == 0));
        check("rsp_cmd_ready", 32'(cmd_ready[k]), 32'd0);
        if (pend >= 0) begin
            cmd_valid[k] = 1'b1;
            cmd_op[k]    = 4'd9;
            cmd_data[k]  = 8'(pend);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
            check("hold_rsp_data", 32'(rsp_data[k]), 32'(exp));
            check("hold_cmd_ready", 32'(cmd_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready[k]), 32'd1);
        check("post_rsp_data", 32'(rsp_data[k]), 32'(exp));
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_op[k] = 4'd0;
            cmd_data[k] = 8'd0; rsp_ready[k] = 1'b0; acc_m[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_cmd_ready", 32'(cmd_ready[k]), 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("init_cmd_ready", 32'(cmd_ready[k]), 32'd1);
            check("init_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("init_rsp_data", 32'(rsp_data[k]), 32'd0);
            check("init_rsp_zero", 32'(rsp_zero[k]), 32'd1);
            check("init_busy", 32'(busy[k]), 32'd0);
            check("init_alu_a", 32'(alu_a[k]), 32'd0);
            check("init_alu_b", 32'(alu_b[k]), 32'd0);
            check("init_alu_op", 32'(alu_op[k]), 32'd0);
        end

        // LAT=1 directed: load/add, wrap, subtract to zero
        do_cmd(0, 9, 5, 0, -1);
        do_cmd(0, 0, 3, 0, -1);
        check("load_add_acc", 32'(rsp_data[0]), 32'd8);
        do_cmd(0, 9, 200, 0, -1);
        do_cmd(0, 0, 100, 0, -1);
        check("wrap_acc", 32'(rsp_data[0]), 32'd44);
        do_cmd(0, 1, 44, 0, -1);
        check("sub_zero", 32'(rsp_zero[0]), 32'd1);

        // LAT=3 directed: operands held stable through EXEC
        do_cmd(1, 9, 6, 0, -1);
        do_cmd(1, 2, 7, 0, -1);
        check("mul_acc", 32'(rsp_data[1]), 32'd42);

        // Backpressure with a second command waiting
        do_cmd(0, 9, 17, 0, -1);
        do_cmd(0, 5, 8, 5, 77);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        acc_m[0] = 77;
        check("pend_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        check("pend_rsp_data", 32'(rsp_data[0]), 32'd77);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("pend_done_ready", 32'(cmd_ready[0]), 32'd1);

        // Reset during EXEC aborts the in-flight ADD
        do_cmd(1, 9, 9, 0, -1);
        @(negedge clk);
        cmd_valid[1] = 1'b1; cmd_op[1] = 4'd0; cmd_data[1] = 8'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        check("abort_busy", 32'(busy[1]), 32'd1);
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rst_ready", 32'(cmd_ready[1]), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("abort_acc", 32'(rsp_data[1]), 32'd0);
        check("abort_alu_op", 32'(alu_op[1]), 32'd0);
        rst[1] = 1'b0;
        acc_m[1] = 0;
        @(negedge clk);
        check("abort_ready_after", 32'(cmd_ready[1]), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        do_cmd(1, 15, 8'($urandom_range(1, 255)), 0, -1);
        check("op15_zero", 32'(rsp_zero[1]), 32'd1);

        // Random streams on both latencies
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 40; i++) begin
                do_cmd(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 3)), -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Accumulator-based command sequencer that drives the operand/opcode inputs of the team's combinational `alu` and captures its result. Commands arrive over a valid/ready handshake. Each command either loads the accumulator directly or is issued to the ALU with the accumulator as `a` and the command data as `b`. The ALU output is written back to the accumulator and returned over a second valid/ready handshake. The block sits between a command source (test sequencer or small controller) and one `alu` instance.

## Interface
Parameters:
- `N`, default 8: data width; must match the attached `alu`.
- `LAT`, default 1: number of cycles `alu_a/alu_b/alu_op` are held before `alu_result` is sampled; LAT >= 1.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  4: opcode; 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NOT, 7 SLL, 8 SRL, 9 LOAD; 10–15 are issued to the ALU unchanged.
- `cmd_data`  in  N: operand `b`, or the load value for LOAD.
- `alu_a`  out  N: ALU operand a; always equals the accumulator.
- `alu_b`  out  N: ALU operand b; the latched `cmd_data`.
- `alu_op`  out  4: ALU operation; the latched `cmd_op`.
- `alu_result`  in  N: ALU result.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_data`  out  N: accumulator value after the command.
- `rsp_zero`  out  1: `rsp_data == 0`.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `cmd_ready=1`. On `cmd_valid && cmd_ready`, latch `cmd_op` and `cmd_data`.
  - If the op is LOAD: `acc <= cmd_data`, next state RESP.
  - Otherwise: clear the latency counter, next state EXEC.
- EXEC: `alu_b` and `alu_op` are held from the latch registers, and `alu_a` equals `acc`. All three stay stable for the whole state. The counter increments each cycle. On the cycle the counter equals LAT-1: `acc <= alu_result`, next state RESP.
- RESP: `rsp_valid=1`, `rsp_data=acc`. On `rsp_ready`, next state IDLE. Without `rsp_ready`, hold the state and all outputs.
- `cmd_ready` is 1 only in IDLE and never while `rst` is high. A command presented outside IDLE is not consumed.
- Width rules: `acc` is N bits and `alu_result` is taken as-is. Any truncation (ADD carry, MUL high half) happens inside the ALU and is not visible here. The latency counter is `$clog2(LAT+1)` bits wide.
- Opcodes 10–15 are not trapped; `acc` takes whatever the ALU returns (0 for the current ALU).

## Timing
- Reset (rst high at an edge): state=IDLE, acc=0, latched op=0, latched data=0, counter=0.
  - Resulting outputs: `rsp_valid=0`, `busy=0`, `alu_a=0`, `alu_b=0`, `alu_op=0`, `rsp_data=0`, `rsp_zero=1`.
  - `cmd_ready` is 0 during the reset cycle and 1 in the first cycle after.
- Reset mid-EXEC or mid-RESP: aborts immediately to the reset values. There is no writeback and no response for the in-flight command.
- Accept at edge 0. Non-LOAD: EXEC occupies cycles 1..LAT, `acc` updates at the end of cycle LAT, and `rsp_valid` is high from cycle LAT+1.
- LOAD: `rsp_valid` is high in cycle 1.
- Response handshake completes at the edge where `rsp_valid && rsp_ready`. `cmd_ready` is high in the following cycle.
- Throughput with `rsp_ready` tied high: one ALU command per LAT+2 cycles; one LOAD per 2 cycles.
- `rsp_data` and `rsp_zero` are registered-state derived (from `acc`) with no combinational path from `alu_result`.
- No combinational path from `cmd_*` or `rsp_ready` to any output.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum with the ten opcodes above (4 bits), reused by `alu` callers.
  - `seq_state_t` enum {IDLE, EXEC, RESP}.
  - Localparam `OP_LOAD = 4'd9`.
- Single module, no sub-module. The `alu` is instantiated beside the sequencer by the integrating level (or the bench), not inside it.

## Test plan
Bench: `alu_sequencer` (N=8) wired to `alu` (N=8).
- Reset then idle: after reset `cmd_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_zero=1`, `busy=0`.
- LOAD 5, then ADD 3 (LAT=1): LOAD response in cycle 1 with `rsp_data=5`; ADD response with `rsp_data=8` and `rsp_valid` at accept+2.
- LOAD 200, ADD 100: `rsp_data=44` (8-bit wrap). Then SUB 44: `rsp_data=0`, `rsp_zero=1`.
- LAT=3, LOAD 6, MUL 7: `alu_a/alu_b/alu_op` are stable (6, 7, 2) for 3 cycles; response `rsp_data=42` at accept+4.
- Backpressure: hold `rsp_ready=0` for 5 cycles in RESP. `rsp_data` stays constant, `cmd_ready=0`, and a second command held valid is not consumed until 1 cycle after the response handshake.
- Reset asserted during EXEC of ADD (acc=9): no response, `acc=0`, `cmd_ready=1` in the cycle after reset deasserts. Opcode 15 afterwards gives `rsp_data=0`, `rsp_zero=1`.
